// File: rtl/alu_pkg.sv
// Shared ALU definitions: the multiplier datapath width and the mult_acc_ctrl FSM state encoding.
package alu_pkg;

  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StAcc  = 2'd2,
    StDone = 2'd3
  } mac_state_e;

endpackage

// File: rtl/mult_acc_add.sv
// Accumulator adder with carry-out. Saturates on carry when MULT_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^ACCW.
module mult_acc_add #(
  parameter int unsigned ACCW = 12
) (
  input  logic [ACCW-1:0] i_acc,
  input  logic [ACCW-1:0] i_prod,
  output logic [ACCW-1:0] o_sum,
  output logic            o_carry
);

  logic [ACCW:0] w_full;

  assign w_full  = {1'b0, i_acc} + {1'b0, i_prod};
  assign o_carry = w_full[ACCW];

`ifdef MULT_ACC_SAT_EN
  assign o_sum = o_carry ? {ACCW{1'b1}} : w_full[ACCW-1:0];
`else
  assign o_sum = w_full[ACCW-1:0];
`endif

endmodule

// File: rtl/mult_acc_ctrl.sv
// Sequences operand pairs onto the external MULT unit and accumulates its products into one
// result per transaction. Saturating accumulation is selected with MULT_ACC_SAT_EN.
module mult_acc_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned ACCW    = 12,
  parameter int unsigned CNTW    = 8,
  parameter int unsigned MAX_CNT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  input  logic            in_last,
  output logic [DW-1:0]   mult_a,
  output logic [DW-1:0]   mult_b,
  input  logic [DW-1:0]   mult_c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc,
  output logic [CNTW-1:0] out_count,
  output logic            out_ovf
);

  mac_state_e      r_state, w_state_next;
  logic            r_last;
  logic [ACCW-1:0] r_prod, r_acc;
  logic [CNTW-1:0] r_cnt;
  logic            r_ovf;
  logic [DW-1:0]   r_mult_a, r_mult_b;

  logic [ACCW-1:0] w_sum;
  logic            w_carry;
  logic [CNTW-1:0] w_cnt_inc;
  logic            w_hs_in;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_hs_in   = (r_state == StIdle) && in_valid;

  mult_acc_add #(
    .ACCW (ACCW)
  ) u_add (
    .i_acc   (r_acc),
    .i_prod  (r_prod),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: if (in_valid) w_state_next = StMul;
        StMul:  w_state_next = StAcc;
        StAcc:  w_state_next = (r_last || (w_cnt_inc == CNTW'(MAX_CNT))) ? StDone : StIdle;
        StDone: if (out_ready) w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mult_a <= '0;
      r_mult_b <= '0;
      r_last   <= 1'b0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else if (clr) begin
      r_mult_a <= '0;
      r_mult_b <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_hs_in) begin
        r_mult_a <= in_a;
        r_mult_b <= in_b;
        r_last   <= in_last;
      end
      // MULT has had a full cycle since the operands were registered.
      if (r_state == StMul) begin
        r_prod <= ACCW'(mult_c);
      end
      if (r_state == StAcc) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc;
        r_ovf <= r_ovf | w_carry;
      end
      if ((r_state == StDone) && out_ready) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign mult_a    = r_mult_a;
  assign mult_b    = r_mult_b;
  assign out_acc   = r_acc;
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mult_acc_ctrl.sv
// Self-checking bench for mult_acc_ctrl: directed cases plus random transactions scored against
// an arithmetic model of the running sum. Expects MULT_ACC_SAT_EN to match the DUT build.
module tb_mult_acc_ctrl;

  localparam int ACCW   = 12;
  localparam int ACCMAX = (1 << ACCW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic [7:0]  mult_a, mult_b, mult_c;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_acc;
  logic [7:0]  out_count;
  logic        out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the transaction in progress.
  int m_acc = 0;
  int m_cnt = 0;
  int m_ovf = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external MULT unit.
  assign mult_c = 8'((int'(mult_a) * int'(mult_b)) & 255);

  mult_acc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_c    (mult_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic model_add(input logic [7:0] a, input logic [7:0] b);
    int tot;
    tot = m_acc + ((int'(a) * int'(b)) & 255);
    if (tot > ACCMAX) m_ovf = 1;
`ifdef MULT_ACC_SAT_EN
    m_acc = (tot > ACCMAX) ? ACCMAX : tot;
`else
    m_acc = tot % (ACCMAX + 1);
`endif
    m_cnt++;
  endtask

  // Called at a falling edge; returns at the falling edge just after the handshake.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_before_pair", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("mult_a_latched", 32'(mult_a), 32'(a));
    chk("mult_b_latched", 32'(mult_b), 32'(b));
    chk("in_ready_in_mul", 32'(in_ready), 32'd0);
    model_add(a, b);
  endtask

  task automatic take_result(input int hold);
    int t = 0;
    logic [7:0] ma;
    while (!out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_acc", 32'(out_acc), 32'(m_acc));
    chk("out_count", 32'(out_count), 32'(m_cnt));
    chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
    ma = mult_a;
    // Stray in_valid while waiting must not be taken.
    if (hold > 0) in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_acc", 32'(out_acc), 32'(m_acc));
      chk("hold_out_count", 32'(out_count), 32'(m_cnt));
      chk("hold_mult_a", 32'(mult_a), 32'(ma));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_result_in_ready", 32'(in_ready), 32'd1);
    chk("post_result_out_valid", 32'(out_valid), 32'd0);
    chk("post_result_acc", 32'(out_acc), 32'd0);
    chk("post_result_count", 32'(out_count), 32'd0);
    chk("post_result_ovf", 32'(out_ovf), 32'd0);
    model_clear();
  endtask

  initial begin
    int len;
    logic [7:0] a, b;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", 32'(mult_b), 32'd0);
    chk("rst_out_acc", 32'(out_acc), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset while in MUL
    send_pair(8'd9, 8'd9, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_mult_a", 32'(mult_a), 32'd0);
    chk("midrst_mult_b", 32'(mult_b), 32'd0);
    chk("midrst_out_acc", 32'(out_acc), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pair with latency check: result appears at the third falling edge after handshake
    send_pair(8'd7, 8'd3, 1'b1);
    @(negedge clk);
    chk("latency_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("single_acc_21", 32'(out_acc), 32'd21);
    take_result(0);

    // Four pairs, 16*16 truncates to 0
    send_pair(8'd7, 8'd3, 1'b0);
    send_pair(8'd5, 8'd5, 1'b0);
    send_pair(8'd2, 8'd10, 1'b0);
    send_pair(8'd16, 8'd16, 1'b1);
    chk("four_pair_model_66", 32'(m_acc), 32'd66);
    take_result(5);

    // 17 x (255*1): overflow, wrap or saturate
    for (int i = 0; i < 17; i++) send_pair(8'd255, 8'd1, (i == 16));
    take_result(0);

    // clr during the ACC cycle of pair 2
    send_pair(8'd7, 8'd3, 1'b0);
    send_pair(8'd5, 8'd5, 1'b0);
    @(negedge clk);
    clr       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_count", 32'(out_count), 32'd0);
    chk("clr_acc", 32'(out_acc), 32'd0);
    chk("clr_mult_a", 32'(mult_a), 32'd0);
    model_clear();
    send_pair(8'd7, 8'd3, 1'b1);
    take_result(0);

    // Random transactions
    for (int txn = 0; txn < 8; txn++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        send_pair(a, b, (i == len - 1));
      end
      take_result($urandom_range(0, 3));
    end

    // Sample-count limit ends the transaction without in_last
    for (int i = 0; i < 255; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send_pair(a, b, 1'b0);
    end
    take_result(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
